// File: rtl/jam_perm_gen_if.sv
// Pair stream from the permutation generator to the cost-table read stage.
// The master drives W/J/perm_last/valid; the slave answers with ready.
interface jam_perm_gen_if #(
    parameter int IDX_W = 3
);
    logic             valid;
    logic             ready;
    logic [IDX_W-1:0] W;
    logic [IDX_W-1:0] J;
    logic             perm_last;

    modport master (output valid, W, J, perm_last, input ready);
    modport slave  (input valid, W, J, perm_last, output ready);
endinterface

// File: rtl/jam_perm_gen.sv
// Lexicographic worker->job permutation enumerator streaming (W, J=perm[W]) pairs.
// Optional macro PERM_COUNT_EN adds a perm_cnt output counting finished permutations.
module jam_perm_gen #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    jam_perm_gen_if.master pair,
    output logic           perm_done,
    output logic           busy
`ifdef PERM_COUNT_EN
    ,
    output logic [15:0]    perm_cnt
`endif
);

    localparam int PW = N * IDX_W;

    typedef enum logic [2:0] {IDLE, EMIT, PIVOT, SWAP, FIN} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    perm_q, perm_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] pivIdx_q, pivIdx_d;
    logic [IDX_W-1:0] succIdx_q, succIdx_d;

    logic [PW-1:0]    identity;
    logic [PW-1:0]    swapped;
    logic [PW-1:0]    rearranged;
    logic             pivFound;
    logic [IDX_W-1:0] pivIdx;
    logic [IDX_W-1:0] succIdx;
    logic [IDX_W-1:0] pivVal;
    logic             lastXfer;

    always_comb begin
        identity = '0;
        for (int m = 0; m < N; m++) begin
            identity[m*IDX_W +: IDX_W] = IDX_W'(m);
        end
    end

    // Later matches overwrite earlier ones, so both searches yield the largest qualifying index.
    always_comb begin
        pivFound = 1'b0;
        pivIdx   = '0;
        for (int m = 0; m < N - 1; m++) begin
            if (perm_q[m*IDX_W +: IDX_W] < perm_q[(m+1)*IDX_W +: IDX_W]) begin
                pivFound = 1'b1;
                pivIdx   = IDX_W'(m);
            end
        end
        pivVal  = perm_q[int'(pivIdx)*IDX_W +: IDX_W];
        succIdx = '0;
        for (int m = 0; m < N; m++) begin
            if ((m > int'(pivIdx)) && (perm_q[m*IDX_W +: IDX_W] > pivVal)) begin
                succIdx = IDX_W'(m);
            end
        end
    end

    always_comb begin
        swapped = perm_q;
        swapped[int'(pivIdx_q)*IDX_W +: IDX_W]  = perm_q[int'(succIdx_q)*IDX_W +: IDX_W];
        swapped[int'(succIdx_q)*IDX_W +: IDX_W] = perm_q[int'(pivIdx_q)*IDX_W +: IDX_W];
        rearranged = swapped;
        for (int m = 0; m < N; m++) begin
            if (m > int'(pivIdx_q)) begin
                rearranged[m*IDX_W +: IDX_W] = swapped[(N + int'(pivIdx_q) - m)*IDX_W +: IDX_W];
            end
        end
    end

    assign lastXfer = (state_q == EMIT) && (k_q == IDX_W'(N - 1)) && pair.ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            perm_q    <= identity;
            k_q       <= '0;
            pivIdx_q  <= '0;
            succIdx_q <= '0;
        end else begin
            state_q   <= state_d;
            perm_q    <= perm_d;
            k_q       <= k_d;
            pivIdx_q  <= pivIdx_d;
            succIdx_q <= succIdx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        perm_d    = perm_q;
        k_d       = k_q;
        pivIdx_d  = pivIdx_q;
        succIdx_d = succIdx_q;
        case (state_q)
            IDLE: begin
                perm_d = identity;
                k_d    = '0;
                if (start) state_d = EMIT;
            end
            EMIT: begin
                if (pair.ready) begin
                    if (k_q == IDX_W'(N - 1)) begin
                        k_d     = '0;
                        state_d = PIVOT;
                    end else begin
                        k_d = k_q + IDX_W'(1);
                    end
                end
            end
            PIVOT: begin
                if (pivFound) begin
                    pivIdx_d  = pivIdx;
                    succIdx_d = succIdx;
                    state_d   = SWAP;
                end else begin
                    state_d = FIN;
                end
            end
            SWAP: begin
                perm_d  = rearranged;
                state_d = EMIT;
            end
            FIN: begin
                perm_d  = identity;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pair.valid     = (state_q == EMIT);
        pair.W         = k_q;
        pair.J         = perm_q[int'(k_q)*IDX_W +: IDX_W];
        pair.perm_last = (state_q == EMIT) && (k_q == IDX_W'(N - 1));
        perm_done      = (state_q == FIN);
        busy           = (state_q == EMIT) || (state_q == PIVOT) || (state_q == SWAP);
    end

`ifdef PERM_COUNT_EN
    logic [15:0] cnt_q;

    // The count survives FIN and IDLE so the total can be read after the run.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            cnt_q <= '0;
        end else if (lastXfer) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign perm_cnt = cnt_q;
`else
    logic unusedLastXfer;
    assign unusedLastXfer = lastXfer;
`endif

endmodule

// File: tb/tb_jam_perm_gen.sv
// Scoreboard bench: an N=4 generator (full runs, random backpressure, reset mid-run)
// and an N=3 generator (non power-of-two index range) checked against hand-listed permutations.
module tb_jam_perm_gen;

    localparam int NA = 4;
    localparam int IWA = 2;
    localparam int NB = 3;
    localparam int IWB = 2;

    typedef struct {
        int w;
        int j;
        int last;
    } pair_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rstA = 1'b1, startA = 1'b0, doneA, busyA;
    logic rstB = 1'b1, startB = 1'b0, doneB, busyB;
    jam_perm_gen_if #(.IDX_W(IWA)) busA ();
    jam_perm_gen_if #(.IDX_W(IWB)) busB ();
`ifdef PERM_COUNT_EN
    logic [15:0] cntA, cntB;
`endif

    jam_perm_gen #(.N(NA), .IDX_W(IWA)) dutA (
        .CLK(CLK), .RST(rstA), .start(startA), .pair(busA.master),
        .perm_done(doneA), .busy(busyA)
`ifdef PERM_COUNT_EN
        , .perm_cnt(cntA)
`endif
    );

    jam_perm_gen #(.N(NB), .IDX_W(IWB)) dutB (
        .CLK(CLK), .RST(rstB), .start(startB), .pair(busB.master),
        .perm_done(doneB), .busy(busyB)
`ifdef PERM_COUNT_EN
        , .perm_cnt(cntB)
`endif
    );

    logic [15:0] perms4 [24] = '{
        16'h0123, 16'h0132, 16'h0213, 16'h0231, 16'h0312, 16'h0321,
        16'h1023, 16'h1032, 16'h1203, 16'h1230, 16'h1302, 16'h1320,
        16'h2013, 16'h2031, 16'h2103, 16'h2130, 16'h2301, 16'h2310,
        16'h3012, 16'h3021, 16'h3102, 16'h3120, 16'h3201, 16'h3210};
    logic [11:0] perms3 [6] = '{12'h012, 12'h021, 12'h102, 12'h120, 12'h201, 12'h210};

    pair_t expA[$];
    pair_t expB[$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int doneCntA = 0, doneCntB = 0;
    int doneCycA = 0, doneCycB = 0;
    int startCycA = 0, startCycB = 0;

    always @(posedge CLK) cyc++;

    task automatic checkOutput(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic pushA(input int nPerms, input int extraPairs);
        pair_t e;
        for (int p = 0; p <= nPerms; p++) begin
            for (int m = 0; m < NA; m++) begin
                if (p < nPerms || m < extraPairs) begin
                    e.w = m;
                    e.j = int'((perms4[p] >> (4 * (NA - 1 - m))) & 16'hF);
                    e.last = (m == NA - 1) ? 1 : 0;
                    expA.push_back(e);
                end
            end
        end
    endtask

    task automatic pushB();
        pair_t e;
        for (int p = 0; p < 6; p++) begin
            for (int m = 0; m < NB; m++) begin
                e.w = m;
                e.j = int'((perms3[p] >> (4 * (NB - 1 - m))) & 12'hF);
                e.last = (m == NB - 1) ? 1 : 0;
                expB.push_back(e);
            end
        end
    endtask

    // Monitor A: scoreboard pop on each transfer, plus hold-stability under backpressure.
    logic holdValid = 1'b0;
    int holdW = 0, holdJ = 0, holdLast = 0;
    always @(negedge CLK) begin
        pair_t e;
        if (holdValid && busA.valid) begin
            checkOutput("A_hold_W", int'(busA.W), holdW);
            checkOutput("A_hold_J", int'(busA.J), holdJ);
            checkOutput("A_hold_last", int'(busA.perm_last), holdLast);
        end
        holdValid = busA.valid && !busA.ready;
        holdW = int'(busA.W);
        holdJ = int'(busA.J);
        holdLast = int'(busA.perm_last);
        if (busA.valid && busA.ready) begin
            if (expA.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL A_extra_pair: got W=%0d J=%0d, required no transfer", busA.W, busA.J);
            end else begin
                e = expA.pop_front();
                checkOutput("A_W", int'(busA.W), e.w);
                checkOutput("A_J", int'(busA.J), e.j);
                checkOutput("A_last", int'(busA.perm_last), e.last);
            end
        end
        if (doneA) begin
            doneCntA++;
            doneCycA = cyc;
            checkOutput("A_busy_at_done", int'(busyA), 0);
`ifdef PERM_COUNT_EN
            checkOutput("A_cnt_at_done", int'(cntA), 24);
`endif
        end
    end

    always @(negedge CLK) begin
        pair_t e;
        if (busB.valid && busB.ready) begin
            if (expB.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL B_extra_pair: got W=%0d J=%0d, required no transfer", busB.W, busB.J);
            end else begin
                e = expB.pop_front();
                checkOutput("B_W", int'(busB.W), e.w);
                checkOutput("B_J", int'(busB.J), e.j);
                checkOutput("B_last", int'(busB.perm_last), e.last);
            end
        end
        if (doneB) begin
            doneCntB++;
            doneCycB = cyc;
`ifdef PERM_COUNT_EN
            checkOutput("B_cnt_at_done", int'(cntB), 6);
`endif
        end
    end

    task automatic applyStimulus(input bit randomReady);
        @(posedge CLK); #1;
        startA = 1'b1;
        busA.ready = 1'b1;
        @(posedge CLK); #1;
        startA = 1'b0;
        startCycA = cyc;
        busA.ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge CLK);
        checkOutput("A_first_valid", int'(busA.valid), 1);
        checkOutput("A_busy_after_start", int'(busyA), 1);
`ifdef PERM_COUNT_EN
        checkOutput("A_cnt_cleared", int'(cntA), 0);
`endif
    endtask

    task automatic driveA(input bit randomReady, input bit resetWhenDrained, input int glitchCycle);
        int target;
        target = doneCntA + 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK); #1;
            startA = 1'b0;
            if (resetWhenDrained && expA.size() == 0) begin
                busA.ready = 1'b0;
                rstA = 1'b1;
                return;
            end
            if (!resetWhenDrained && doneCntA >= target) return;
            busA.ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            startA = (c == glitchCycle);
        end
        compared++;
        mismatched++;
        $display("[TB] FAIL A_timeout: got no completion in 3000 cycles, required completion");
    endtask

    task automatic checkIdleA(input string tag);
        @(negedge CLK);
        checkOutput({tag, "_valid"}, int'(busA.valid), 0);
        checkOutput({tag, "_busy"}, int'(busyA), 0);
        checkOutput({tag, "_done"}, int'(doneA), 0);
        checkOutput({tag, "_W"}, int'(busA.W), 0);
        checkOutput({tag, "_J"}, int'(busA.J), 0);
        checkOutput({tag, "_last"}, int'(busA.perm_last), 0);
    endtask

    initial begin
        busA.ready = 1'b0;
        busB.ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        rstA = 1'b0;
        rstB = 1'b0;
        checkIdleA("A_reset");
`ifdef PERM_COUNT_EN
        checkOutput("A_reset_cnt", int'(cntA), 0);
`endif

        // N=4 full enumeration with ready held high: exact N+2 cadence.
        pushA(24, 0);
        applyStimulus(1'b0);
        driveA(1'b0, 1'b0, -1);
        checkOutput("A_done_latency", doneCycA - startCycA, 24 * (NA + 2) - 1);
        checkIdleA("A_after_run1");
        checkOutput("A_run1_drained", expA.size(), 0);
        checkOutput("A_run1_done_pulses", doneCntA, 1);

        // Random backpressure with a stray start pulse mid-enumeration.
        pushA(24, 0);
        applyStimulus(1'b1);
        driveA(1'b1, 1'b0, 40);
        checkIdleA("A_after_run2");
        checkOutput("A_run2_drained", expA.size(), 0);
        checkOutput("A_run2_done_pulses", doneCntA, 2);

        // Reset while emitting the fourth permutation, then restart from identity.
        pushA(3, 2);
        applyStimulus(1'b1);
        driveA(1'b1, 1'b1, -1);
        @(posedge CLK); #1;
        rstA = 1'b0;
        checkIdleA("A_midreset");
        checkOutput("A_midreset_no_done", doneCntA, 2);
        pushA(24, 0);
        applyStimulus(1'b0);
        driveA(1'b0, 1'b0, -1);
        checkOutput("A_run3_drained", expA.size(), 0);
        checkOutput("A_run3_done_pulses", doneCntA, 3);

        // N=3: index range not a power of two.
        pushB();
        @(posedge CLK); #1;
        startB = 1'b1;
        @(posedge CLK); #1;
        startB = 1'b0;
        startCycB = cyc;
        for (int c = 0; c < 200 && doneCntB == 0; c++) @(posedge CLK);
        #1;
        checkOutput("B_done_pulses", doneCntB, 1);
        checkOutput("B_done_latency", doneCycB - startCycB, 6 * (NB + 2) - 1);
        checkOutput("B_drained", expB.size(), 0);
        @(negedge CLK);
        checkOutput("B_busy_after", int'(busyB), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
